hilo_muldiv_ctrl: RTL

Multi-cycle multiply/divide controller that owns the HI/LO register pair. Sits in the execute stage beside the ALU: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops flagged by decode through `mult_en`, sequences the iterative divider and the fixed-latency multiplier, and raises `busy` so the pipeline stalls dependent MFHI/MFLO reads and further HI/LO ops.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 37 +++
 rtl/hilo_muldiv_ctrl_div_step.sv | 38 +++
 rtl/hilo_muldiv_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl_pkg
// Shared types and constants for the HI/LO multiply/divide controller:
//   muldiv_op_t    - op encodings driven by decode (MD_*)
//   muldiv_state_t - controller FSM states
//   DIV_STEPS      - restoring-divider iteration count
//   abs32()        - magnitude of a 32-bit operand (signed or raw)
// -----------------------------------------------------------------------------
package hilo_muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } muldiv_state_t;

   localparam int DIV_STEPS = 32;
   // Wide enough for DIV_STEPS and for MUL_LATENCY-1 (max 14).
   localparam int CNT_W     = 6;

   // Two's-complement magnitude when is_signed, raw value otherwise.
   // 0x80000000 maps to itself, which the unsigned divider handles correctly.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The quotient register
// initially holds the dividend; its MSB is shifted into the partial remainder
// each step and the new quotient bit enters at the LSB.
// Ports:
//   rem_in  [31:0] - partial remainder before this step
//   quo_in  [31:0] - remaining dividend bits / quotient bits so far
//   divisor [31:0] - divisor magnitude
//   rem_out [31:0] - partial remainder after this step
//   quo_out [31:0] - shifted quotient with the new bit in [0]
// -----------------------------------------------------------------------------
module div_step (
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);

   logic [32:0] rem_shift;
   logic [31:0] diff;

   assign rem_shift = {rem_in, quo_in[31]};
   // When the trial subtract succeeds the result is below the divisor,
   // so the low 32 bits of the difference are exact.
   assign diff      = rem_shift[31:0] - divisor;

   always_comb begin
      rem_out = rem_shift[31:0];
      quo_out = {quo_in[30:0], 1'b0};
      if (rem_shift >= {1'b0, divisor}) begin
         rem_out = diff;
         quo_out = {quo_in[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// MTHI/MTLO write on the accept edge. MULT/MULTU compute the product at accept
// and hold it for MUL_LATENCY edges. DIV/DIVU run a 32-step restoring divider
// followed by a sign-fix cycle. flush aborts without touching HI/LO.
//
// Optional build macro: HILO_DIV0_FAST_EN - a zero divisor seen at accept
// skips the 32 iterations and goes straight to the sign-fix cycle.
//
// Parameters:
//   MUL_LATENCY - edges from multiply accept to the HI/LO write (1..15)
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   op_valid, op       - op request and its encoding
//   src_a, src_b       - rs / rt operands
//   flush              - abort the in-flight op
//   op_ready           - controller idle, request can be accepted
//   busy               - multiply or divide in flight
//   done               - one-cycle pulse after a MUL/DIV HI/LO write
//   hi, lo             - committed HI / LO
// -----------------------------------------------------------------------------
module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  muldiv_op_t  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        op_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t    state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [63:0]      prod_reg;
   logic [31:0]      rem_reg;
   logic [31:0]      quo_reg;
   logic [31:0]      dvsr_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;
   logic [31:0]      hi_reg;
   logic [31:0]      lo_reg;
   logic             done_reg;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] step_rem;
   logic [31:0] step_quo;
   logic        div_signed;

   assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
   assign prod_u = {32'd0, src_a} * {32'd0, src_b};
   assign div_signed = (op == MD_DIV);

   div_step u_div_step (
      .rem_in  (rem_reg),
      .quo_in  (quo_reg),
      .divisor (dvsr_reg),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   assign op_ready = (state_reg == S_IDLE) && !reset;
   assign busy     = (state_reg != S_IDLE);
   assign done     = done_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         prod_reg  <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvsr_reg  <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (op_valid) begin
                     case (op)
                        MD_MTHI: hi_reg <= src_a;
                        MD_MTLO: lo_reg <= src_a;
                        MD_MULT, MD_MULTU: begin
                           prod_reg  <= (op == MD_MULT) ? prod_s : prod_u;
                           cnt_reg   <= CNT_W'(MUL_LATENCY - 1);
                           state_reg <= S_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                           dvsr_reg  <= abs32(src_b, div_signed);
                           neg_q_reg <= div_signed && (src_a[31] ^ src_b[31]);
                           neg_r_reg <= div_signed && src_a[31];
`ifdef HILO_DIV0_FAST_EN
                           if (src_b == 32'd0) begin
                              // What 32 restoring steps would yield with a
                              // zero divisor: all-ones quotient, |a| remainder.
                              rem_reg   <= abs32(src_a, div_signed);
                              quo_reg   <= 32'hFFFF_FFFF;
                              cnt_reg   <= '0;
                              state_reg <= S_FIX;
                           end else begin
                              rem_reg   <= '0;
                              quo_reg   <= abs32(src_a, div_signed);
                              cnt_reg   <= CNT_W'(DIV_STEPS);
                              state_reg <= S_DIV;
                           end
`else
                           rem_reg   <= '0;
                           quo_reg   <= abs32(src_a, div_signed);
                           cnt_reg   <= CNT_W'(DIV_STEPS);
                           state_reg <= S_DIV;
`endif
                        end
                        default: ;  // unknown encoding: accepted, ignored
                     endcase
                  end
               end
               S_MUL: begin
                  if (cnt_reg == '0) begin
                     hi_reg    <= prod_reg[63:32];
                     lo_reg    <= prod_reg[31:0];
                     done_reg  <= 1'b1;
                     state_reg <= S_IDLE;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               S_DIV: begin
                  rem_reg <= step_rem;
                  quo_reg <= step_quo;
                  cnt_reg <= cnt_reg - 1'b1;
                  if (cnt_reg == CNT_W'(1)) begin
                     state_reg <= S_FIX;
                  end
               end
               S_FIX: begin
                  // Divide-by-zero falls out of the same rules: a negative
                  // dividend yields quotient 1 and remainder a.
                  lo_reg    <= neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
                  hi_reg    <= neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
                  done_reg  <= 1'b1;
                  state_reg <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

endmodule
